// File: rtl/icd_cmd_engine.sv
// ICD frame decoder: header/address/data bytes to single-byte bus cycles.
// Optional bus watchdog enabled by defining ICD_BUS_TIMEOUT_EN.
module icd_cmd_engine #(
  parameter int         TIMEOUT_CYC = 255,
  parameter logic [7:0] IDLE_TX     = 8'h00
) (
  input  logic        clk6x,
  input  logic        reset,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_hdr_en_i,
  input  logic        rx_db_en_i,
  output logic [7:0]  tx_byte_o,
  output logic        tx_en_o,
  output logic [23:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  output logic        bus_rd_o,
  output logic        bus_wr_o,
  input  logic [7:0]  bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR0, S_ADDR1, S_ADDR2, S_WDATA,
    S_WBUS, S_RBUS, S_RDATA, S_IGNORE
  } state_t;

  state_t      state, state_d;
  logic        cmd_wr, cmd_wr_d;
  logic        ainc, ainc_d;
  logic [23:0] addr, addr_d, addr_inc;
  logic [7:0]  wdat, wdat_d;
  logic        ovr, ovr_d;
  logic        tmo, tmo_d;
  logic        disc, disc_d;
  logic        pend, pend_d;
  logic        rd_d, wr_d, txen_d;
  logic [23:0] baddr_d;
  logic [7:0]  bwdat_d, txb_d;
  logic        busy, done, own, req, tmo_hit;

  assign busy     = bus_rd_o | bus_wr_o;
  assign busy_o   = busy;
  assign done     = busy & (bus_ack_i | tmo_hit);
  assign own      = done & ~disc & ~rx_hdr_en_i;
  assign addr_inc = addr + {23'd0, ainc};

`ifdef ICD_BUS_TIMEOUT_EN
  logic [7:0] cnt;

  assign tmo_hit = busy & ~bus_ack_i &
                   (cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk6x) begin
    if (reset || !busy || done) cnt <= 8'd0;
    else                        cnt <= cnt + 8'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state;
    cmd_wr_d = cmd_wr;
    ainc_d   = ainc;
    addr_d   = addr;
    wdat_d   = wdat;
    ovr_d    = ovr;
    tmo_d    = tmo;
    disc_d   = disc;
    pend_d   = pend;
    rd_d     = bus_rd_o;
    wr_d     = bus_wr_o;
    baddr_d  = bus_addr_o;
    bwdat_d  = bus_wdata_o;
    txb_d    = tx_byte_o;
    txen_d   = 1'b0;
    req      = 1'b0;

    if (done) begin
      rd_d   = 1'b0;
      wr_d   = 1'b0;
      disc_d = 1'b0;
    end

    if (own) begin
      if (bus_wr_o) begin
        addr_d  = addr_inc;
        state_d = S_WDATA;
      end else begin
        txb_d   = bus_ack_i ? bus_rdata_i : 8'hFF;
        txen_d  = 1'b1;
        state_d = S_RDATA;
      end
      if (!bus_ack_i) tmo_d = 1'b1;
    end

    if (rx_hdr_en_i) begin
      pend_d = 1'b0;
      // an abandoned request keeps running; its result is dropped
      if (busy && !done) disc_d = 1'b1;
      unique case (1'b1)
        rx_byte_i[3:0] == 4'd0: begin
          txb_d   = {ovr, tmo, 2'b00, state};
          txen_d  = 1'b1;
          ovr_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_IGNORE;
        end
        rx_byte_i[3:0] == 4'd1,
        rx_byte_i[3:0] == 4'd2: begin
          cmd_wr_d = rx_byte_i[0];
          ainc_d   = rx_byte_i[4];
          txb_d    = IDLE_TX;
          txen_d   = 1'b1;
          state_d  = S_ADDR0;
        end
        default: state_d = S_IGNORE;
      endcase
    end else if (rx_db_en_i) begin
      unique case (state)
        S_ADDR0: begin
          addr_d[7:0] = rx_byte_i;
          state_d     = S_ADDR1;
        end
        S_ADDR1: begin
          addr_d[15:8] = rx_byte_i;
          state_d      = S_ADDR2;
        end
        S_ADDR2: begin
          addr_d[23:16] = rx_byte_i;
          state_d       = cmd_wr ? S_WDATA : S_RBUS;
          req           = ~cmd_wr;
        end
        S_WDATA: begin
          wdat_d  = rx_byte_i;
          state_d = S_WBUS;
          req     = 1'b1;
        end
        S_WBUS, S_RBUS: ovr_d = 1'b1;
        S_RDATA: begin
          addr_d  = addr_inc;
          state_d = S_RBUS;
          req     = 1'b1;
        end
        default: ;
      endcase
    end

    // address/data reach the bus only at issue, so a draining request is untouched
    if ((req || pend) && !rx_hdr_en_i) begin
      if (!busy || done) begin
        rd_d    = ~cmd_wr;
        wr_d    = cmd_wr;
        baddr_d = addr_d;
        bwdat_d = wdat_d;
        pend_d  = 1'b0;
      end else begin
        pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_wr      <= 1'b0;
      ainc        <= 1'b0;
      addr        <= 24'd0;
      wdat        <= 8'd0;
      ovr         <= 1'b0;
      tmo         <= 1'b0;
      disc        <= 1'b0;
      pend        <= 1'b0;
      bus_rd_o    <= 1'b0;
      bus_wr_o    <= 1'b0;
      bus_addr_o  <= 24'd0;
      bus_wdata_o <= 8'd0;
      tx_byte_o   <= 8'd0;
      tx_en_o     <= 1'b0;
    end else begin
      state       <= state_d;
      cmd_wr      <= cmd_wr_d;
      ainc        <= ainc_d;
      addr        <= addr_d;
      wdat        <= wdat_d;
      ovr         <= ovr_d;
      tmo         <= tmo_d;
      disc        <= disc_d;
      pend        <= pend_d;
      bus_rd_o    <= rd_d;
      bus_wr_o    <= wr_d;
      bus_addr_o  <= baddr_d;
      bus_wdata_o <= bwdat_d;
      tx_byte_o   <= txb_d;
      tx_en_o     <= txen_d;
    end
  end

endmodule
